bool_share_loader: RTL and testbench
====================================

Name: bool_share_loader

Overview:
- Upstream feeder for the N-share Boolean full-XOR recombination stage.
- Collects N_SHARES Boolean shares arriving serially, one K_WIDTH word per cycle, on a valid/ready stream.
- Generates the fresh refresh randomness the recombination stage consumes, RANDNUM words from an internal xorshift32 PRNG.
- Presents the parallel share vector and randomness with a dvld qualifier that connects directly to the recombination stage's dvld/i_x/rnd inputs.

Parameters:
- K_WIDTH, 32, share word width. Only 32 is supported; any other value is an elaboration error.
- N_SHARES, 5, number of Boolean shares (>=2).
- MASKWIDTH, K_WIDTH*N_SHARES, width of the parallel share vector.
- LOG_K, $clog2(N_SHARES+1)-1, helper for the randomness count.
- RANDNUM, LOG_K*2**(LOG_K-1)+N_SHARES-2**LOG_K, number of K_WIDTH refresh words per block (5 for N_SHARES=5).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  global enable; when low all state is frozen
- seed_ld  in  1  load PRNG seed and abort the current block
- seed  in  32  PRNG seed value
- s_vld  in  1  input share valid
- s_rdy  out  1  input share ready
- s_share  in  K_WIDTH  serial share word
- o_x  out  MASKWIDTH  parallel shares; first accepted share at [0 +: K_WIDTH]
- o_rnd  out  K_WIDTH*RANDNUM  refresh randomness; word j at [j*K_WIDTH +: K_WIDTH]
- dvld  out  1  o_x/o_rnd complete; drives the recombination stage's dvld
- busy  out  1  high when share_cnt!=0, rnd_cnt!=0, or state!=COLLECT

Behaviour:
- Reset (async, rst_n=0):
  - state=COLLECT; share_cnt=0, rnd_cnt=0.
  - o_x=0, o_rnd=0, dvld=0.
  - PRNG state=32'h2545F491.
- PRNG: xorshift32 step x^=x<<13; x^=x>>17; x^=x<<5. Each generated word is the new state after one step.
- States:
  - COLLECT: accepting shares and generating randomness.
  - WAIT_RND: all shares in, randomness still being generated.
  - ISSUE: block complete, dvld high.
- Evaluation order: all actions happen only on cycles with ena=1; seed_ld has top priority, over every other action.
- seed_ld=1 & ena=1:
  - PRNG<=seed, or 32'h2545F491 if seed==0.
  - share_cnt<=0, rnd_cnt<=0, state<=COLLECT.
  - Partially collected data is discarded; o_x/o_rnd contents are don't-care until the next ISSUE.
- s_rdy = ena & ~seed_ld & (state==COLLECT) & (share_cnt<N_SHARES).
- Handshake: s_vld & s_rdy writes s_share into slot share_cnt and increments share_cnt. s_vld may toggle freely; there is no requirement to hold.
- Randomness: in COLLECT or WAIT_RND with rnd_cnt<RANDNUM, each ena cycle:
  - steps the PRNG;
  - writes the new word to slot rnd_cnt;
  - increments rnd_cnt.
  - This is independent of s_vld.
- Transitions:
  - COLLECT->WAIT_RND when the last share is accepted and rnd_cnt (after update) < RANDNUM.
  - COLLECT->ISSUE when the last share is accepted and randomness is complete.
  - WAIT_RND->ISSUE when the last rnd word is written.
  - If randomness completes before the shares, remain in COLLECT until the last share.
- ISSUE:
  - dvld=(state==ISSUE), combinational from the state register.
  - Leaves on the first ena=1 cycle: ->COLLECT, share_cnt<=0, rnd_cnt<=0.
  - With ena=0, dvld stays high (consumer is frozen too).
- o_x/o_rnd hold their values from ISSUE until overwritten slot-by-slot by the next block. The consumer samples them only at dvld.
- Latency and throughput:
  - With back-to-back s_vld and RANDNUM<=N_SHARES, dvld rises the cycle after the last share is accepted.
  - Throughput is one block per N_SHARES+1 cycles.
  - If RANDNUM>N_SHARES, ISSUE is delayed by RANDNUM-N_SHARES cycles.
- Randomness is never reused across blocks; every block gets RANDNUM fresh steps.
- Reset mid-block aborts immediately to reset values.

Decomposition:
- Package b2a_pkg holds:
  - function randnum(n) (same formula as RANDNUM);
  - function xorshift32_step;
  - localparam PRNG_DEFAULT=32'h2545F491;
  - the state enum COLLECT/WAIT_RND/ISSUE.
- Sub-module share_prng: 32-bit xorshift register with ports clk, rst_n, ena, step, ld, seed, q. Holds value when step=0 or ena=0.

Test Plan:
- Seed 1 via seed_ld, then 5 back-to-back shares 32'h11111111..32'h55555555 → dvld high in cycle 6 after the first accept. Required values:
  - o_x = {55555555,44444444,33333333,22222222,11111111}.
  - o_rnd words 0..4 = 270369, 67634689, 2647435461, 307599695, 2398689233.
- Same seed, with the stimulus driving shares only every third cycle:
  - randomness completes early and the state stays COLLECT;
  - dvld rises the cycle after the fifth accept;
  - o_rnd is identical to the previous scenario.
- ena low for 3 cycles mid-collection (after share 2) → s_rdy=0, no counters or PRNG advance; the final o_x/o_rnd match the uninterrupted run. ena low during ISSUE → dvld held high until ena returns.
- seed_ld asserted after 3 shares with seed=0 → PRNG=32'h2545F491, counters 0. The next 5 shares produce one dvld containing only those 5 shares.
- Two consecutive blocks → second o_rnd continues the sequence with no repeated words. s_rdy is 0 exactly during the ISSUE cycle.
- rst_n pulsed low asynchronously mid-WAIT_RND (N_SHARES=8, RANDNUM=12) → outputs return to zero immediately with no dvld; the next block is issued after 12 rnd cycles.

Source files
------------

// File: rtl/bool_share_loader_pkg.sv
// Shared types, constants and helper functions for the Boolean share loader.
// The xorshift32 step and the refresh-word count formula live here so the loader and its PRNG use one definition.
package b2a_pkg;

    localparam logic [31:0] PRNG_DEFAULT = 32'h2545F491;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        WAIT_RND = 2'd1,
        ISSUE    = 2'd2
    } state_e;

    // Refresh words consumed per block by an n-share full-XOR recombination.
    function automatic int randnum(input int n);
        int lk;
        lk = $clog2(n + 1) - 1;
        return lk * (1 << (lk - 1)) + n - (1 << lk);
    endfunction

    function automatic logic [31:0] xorshift32_step(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

endpackage

// File: rtl/bool_share_loader_if.sv
// Serial share input stream plus the parallel share/randomness output bundle.
// The slave side is the loader; the master side is whoever feeds shares and samples the block.
interface bool_share_loader_if #(
    parameter int K_WIDTH  = 32,
    parameter int N_SHARES = 5
);
    import b2a_pkg::*;

    localparam int MASKWIDTH = K_WIDTH * N_SHARES;
    localparam int RANDNUM   = randnum(N_SHARES);

    logic                         s_vld;
    logic                         s_rdy;
    logic [K_WIDTH-1:0]           s_share;
    logic [MASKWIDTH-1:0]         o_x;
    logic [K_WIDTH*RANDNUM-1:0]   o_rnd;
    logic                         dvld;

    modport slave (
        input  s_vld,
        input  s_share,
        output s_rdy,
        output o_x,
        output o_rnd,
        output dvld
    );

    modport master (
        output s_vld,
        output s_share,
        input  s_rdy,
        input  o_x,
        input  o_rnd,
        input  dvld
    );

endinterface

// File: rtl/bool_share_loader_prng.sv
// 32-bit xorshift register supplying refresh randomness; advances only when stepped while enabled.
// A zero seed would lock xorshift at zero forever, so it is replaced by the default state.
module share_prng
    import b2a_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        step,
    input  logic        ld,
    input  logic [31:0] seed,
    output logic [31:0] q
);

    logic [31:0] r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PRNG_DEFAULT;
        end else if (ena) begin
            if (ld) begin
                r_state <= (seed == 32'd0) ? PRNG_DEFAULT : seed;
            end else if (step) begin
                r_state <= xorshift32_step(r_state);
            end
        end
    end

    assign q = r_state;

endmodule

// File: rtl/bool_share_loader.sv
// Collects N_SHARES serial Boolean shares and RANDNUM fresh PRNG words into parallel vectors,
// then raises dvld for one enabled cycle so the recombination stage can consume the block.
module bool_share_loader
    import b2a_pkg::*;
#(
    parameter int K_WIDTH  = 32,
    parameter int N_SHARES = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  seed_ld,
    input  logic [31:0]           seed,
    bool_share_loader_if.slave    s_if,
    output logic                  busy
);

    localparam int MASKWIDTH = K_WIDTH * N_SHARES;
    localparam int RANDNUM   = randnum(N_SHARES);
    localparam int SCW       = $clog2(N_SHARES + 1);
    localparam int RCW       = $clog2(RANDNUM + 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(N_SHARES - 1);
    localparam logic [SCW-1:0] SC_FULL = SCW'(N_SHARES);
    localparam logic [RCW-1:0] RC_LAST = RCW'(RANDNUM - 1);
    localparam logic [RCW-1:0] RC_FULL = RCW'(RANDNUM);

    if (K_WIDTH != 32) begin : g_width_check
        $error("bool_share_loader: K_WIDTH must be 32");
    end

    state_e                     r_state;
    state_e                     w_state_next;
    logic [SCW-1:0]             r_share_cnt;
    logic [RCW-1:0]             r_rnd_cnt;
    logic                       w_active;
    logic                       w_rdy;
    logic                       w_accept;
    logic                       w_rnd_step;
    logic                       w_last_share;
    logic                       w_rnd_done;
    logic [31:0]                w_prng_q;
    logic [31:0]                w_prng_word;
    logic [MASKWIDTH-1:0]       w_x;
    logic [K_WIDTH*RANDNUM-1:0] w_rnd;

    assign w_active    = ena & ~seed_ld;
    assign w_prng_word = xorshift32_step(w_prng_q);

    share_prng u_prng (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .step  (w_rnd_step),
        .ld    (seed_ld),
        .seed  (seed),
        .q     (w_prng_q)
    );

    always_comb begin
        w_state_next = r_state;
        w_rdy        = w_active && (r_state == COLLECT) && (r_share_cnt < SC_FULL);
        w_accept     = w_rdy && s_if.s_vld;
        w_rnd_step   = w_active && (r_state != ISSUE) && (r_rnd_cnt < RC_FULL);
        w_last_share = w_accept && (r_share_cnt == SC_LAST);
        // Randomness counts as complete if it already was, or if this cycle writes the last word.
        w_rnd_done   = (r_rnd_cnt == RC_FULL) || (w_rnd_step && (r_rnd_cnt == RC_LAST));
        if (ena) begin
            if (seed_ld) begin
                w_state_next = COLLECT;
            end else begin
                case (r_state)
                    COLLECT:  if (w_last_share) w_state_next = w_rnd_done ? ISSUE : WAIT_RND;
                    WAIT_RND: if (w_rnd_done)   w_state_next = ISSUE;
                    ISSUE:    w_state_next = COLLECT;
                    default:  w_state_next = COLLECT;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_share_cnt <= '0;
            r_rnd_cnt   <= '0;
        end else if (ena) begin
            if (seed_ld || (r_state == ISSUE)) begin
                r_share_cnt <= '0;
                r_rnd_cnt   <= '0;
            end else begin
                if (w_accept)   r_share_cnt <= r_share_cnt + 1'b1;
                if (w_rnd_step) r_rnd_cnt   <= r_rnd_cnt + 1'b1;
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < N_SHARES; gi++) begin : g_share_slot
        logic [K_WIDTH-1:0] r_word;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_word <= '0;
            end else if (w_accept && (r_share_cnt == SCW'(gi))) begin
                r_word <= s_if.s_share;
            end
        end
        assign w_x[gi*K_WIDTH +: K_WIDTH] = r_word;
    end

    for (gi = 0; gi < RANDNUM; gi++) begin : g_rnd_slot
        logic [K_WIDTH-1:0] r_word;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_word <= '0;
            end else if (w_rnd_step && (r_rnd_cnt == RCW'(gi))) begin
                r_word <= w_prng_word;
            end
        end
        assign w_rnd[gi*K_WIDTH +: K_WIDTH] = r_word;
    end

    assign s_if.s_rdy = w_rdy;
    assign s_if.o_x   = w_x;
    assign s_if.o_rnd = w_rnd;
    assign s_if.dvld  = (r_state == ISSUE);
    assign busy       = (r_share_cnt != '0) || (r_rnd_cnt != '0) || (r_state != COLLECT);

endmodule

// File: tb/tb_bool_share_loader.sv
// Bench for bool_share_loader: a 5-share instance driven from a vector table and hand sequences,
// plus an 8-share instance for the long-randomness and async-reset corner.
module tb_bool_share_loader;
    import b2a_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n5, ena5, seed_ld5, busy5;
    logic [31:0] seed5;
    logic        rst_n8, ena8, seed_ld8, busy8;
    logic [31:0] seed8;

    bool_share_loader_if #(.K_WIDTH(32), .N_SHARES(5)) if5 ();
    bool_share_loader_if #(.K_WIDTH(32), .N_SHARES(8)) if8 ();

    bool_share_loader #(.K_WIDTH(32), .N_SHARES(5)) dut5 (
        .clk(clk), .rst_n(rst_n5), .ena(ena5), .seed_ld(seed_ld5), .seed(seed5),
        .s_if(if5), .busy(busy5)
    );

    bool_share_loader #(.K_WIDTH(32), .N_SHARES(8)) dut8 (
        .clk(clk), .rst_n(rst_n8), .ena(ena8), .seed_ld(seed_ld8), .seed(seed8),
        .s_if(if8), .busy(busy8)
    );

    typedef struct packed {
        logic [383:0] x;
        logic [383:0] rnd;
    } exp_t;

    typedef struct {
        logic [31:0]  seed;
        int           gap;
        logic [159:0] sh;
        logic [159:0] rnd;
    } vec_t;

    exp_t q5[$];
    exp_t q8[$];
    exp_t e5, e8;
    vec_t tbl[3];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic prev5 = 1'b0;
    logic prev8 = 1'b0;

    task automatic check(input string name, input logic [383:0] got, input logic [383:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] xs(input logic [31:0] v);
        logic [31:0] x;
        x = v;
        x = x ^ {x[18:0], 13'b0};
        x = x ^ {17'b0, x[31:17]};
        x = x ^ {x[26:0], 5'b0};
        return x;
    endfunction

    function automatic logic [383:0] gen_rnd(input logic [31:0] st, input int skip, input int n);
        logic [383:0] r;
        logic [31:0]  s;
        r = '0;
        s = st;
        for (int i = 0; i < skip; i++) s = xs(s);
        for (int i = 0; i < n; i++) begin
            s = xs(s);
            r[i*32 +: 32] = s;
        end
        return r;
    endfunction

    // Scoreboards: one expected block popped per rising dvld.
    always @(negedge clk) begin
        if (if5.dvld && !prev5) begin
            if (q5.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_dvld5: got dvld=1 required no block pending");
            end else begin
                e5 = q5.pop_front();
                check("blk5_x", 384'(if5.o_x), e5.x);
                check("blk5_rnd", 384'(if5.o_rnd), e5.rnd);
                $display("block5 issued x=%h", if5.o_x);
            end
        end
        prev5 <= if5.dvld;
    end

    always @(negedge clk) begin
        if (if8.dvld && !prev8) begin
            if (q8.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_dvld8: got dvld=1 required no block pending");
            end else begin
                e8 = q8.pop_front();
                check("blk8_x", 384'(if8.o_x), e8.x);
                check("blk8_rnd", 384'(if8.o_rnd), e8.rnd);
                $display("block8 issued x=%h", if8.o_x);
            end
        end
        prev8 <= if8.dvld;
    end

    task automatic drive_share5(input logic [31:0] w, output int waited);
        waited = 0;
        if5.s_vld   = 1'b1;
        if5.s_share = w;
        #1;
        while (!if5.s_rdy && waited < 50) begin
            @(negedge clk);
            waited++;
            #1;
        end
        if (!if5.s_rdy) begin
            n_checks++; n_fail++;
            $display("FAIL share_timeout: got s_rdy=0 required 1 within 50 cycles");
        end
        @(negedge clk);
        if5.s_vld = 1'b0;
    endtask

    task automatic send5(input logic [159:0] sh, input int gap, output int first_wait, output int tot_wait);
        int w;
        first_wait = 0;
        tot_wait   = 0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) repeat (gap) @(negedge clk);
            drive_share5(sh[k*32 +: 32], w);
            if (k == 0) first_wait = w;
            tot_wait += w;
        end
    endtask

    task automatic seed_load5(input logic [31:0] sd);
        @(negedge clk);
        seed_ld5 = 1'b1;
        seed5    = sd;
        @(negedge clk);
        seed_ld5 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [383:0] tmp;
        logic [159:0] sh_a, sh_b, sh_c;
        logic [255:0] sh8a, sh8b;
        int fw, tw, w, cyc;

        tbl[0] = '{32'd1, 0,
                   {32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                   {32'd2398689233, 32'd307599695, 32'd2647435461, 32'd67634689, 32'd270369}};
        tbl[1] = tbl[0];
        tbl[1].gap = 2;
        tmp = gen_rnd(32'hDEADBEEF, 0, 5);
        tbl[2] = '{32'hDEADBEEF, 1, '0, tmp[159:0]};
        for (int k = 0; k < 5; k++) tbl[2].sh[k*32 +: 32] = $urandom;

        rst_n5 = 1'b0; ena5 = 1'b1; seed_ld5 = 1'b0; seed5 = '0;
        rst_n8 = 1'b0; ena8 = 1'b1; seed_ld8 = 1'b0; seed8 = '0;
        if5.s_vld = 1'b0; if5.s_share = '0;
        if8.s_vld = 1'b0; if8.s_share = '0;
        #12;
        check("rst_x", 384'(if5.o_x), 384'd0);
        check("rst_rnd", 384'(if5.o_rnd), 384'd0);
        check("rst_dvld", 384'(if5.dvld), 384'd0);
        check("rst_busy", 384'(busy5), 384'd0);
        @(negedge clk);
        rst_n5 = 1'b1;
        rst_n8 = 1'b1;

        // Table-driven blocks, each starting from a fresh seed.
        for (int v = 0; v < 3; v++) begin
            seed_load5(tbl[v].seed);
            q5.push_back({384'(tbl[v].sh), 384'(tbl[v].rnd)});
            send5(tbl[v].sh, tbl[v].gap, fw, tw);
            check("rdy_stall", 384'(tw), 384'd0);
            check("dvld_lat", 384'(if5.dvld), 384'd1);
            #1;
            check("rdy_issue", 384'(if5.s_rdy), 384'd0);
            $display("vector %0d seed=%h gap=%0d done", v, tbl[v].seed, tbl[v].gap);
        end

        // ena low mid-collection and during ISSUE.
        seed_load5(32'd1);
        q5.push_back({384'(tbl[0].sh), 384'(tbl[0].rnd)});
        drive_share5(tbl[0].sh[31:0], w);
        drive_share5(tbl[0].sh[63:32], w);
        ena5 = 1'b0;
        if5.s_vld = 1'b1;
        if5.s_share = tbl[0].sh[95:64];
        for (int c = 0; c < 3; c++) begin
            #1;
            check("rdy_ena_low", 384'(if5.s_rdy), 384'd0);
            @(negedge clk);
        end
        ena5 = 1'b1;
        for (int k = 2; k < 5; k++) drive_share5(tbl[0].sh[k*32 +: 32], w);
        check("dvld_after_pause", 384'(if5.dvld), 384'd1);
        ena5 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("dvld_hold", 384'(if5.dvld), 384'd1);
        end
        ena5 = 1'b1;
        @(negedge clk);
        check("dvld_release", 384'(if5.dvld), 384'd0);
        $display("ena pause sequence done");

        // seed_ld with seed 0 aborts a partial block.
        sh_a = {32'hA4A4A4A4, 32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
        sh_b = {32'hB4B4B4B4, 32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};
        sh_c = {32'hC4C4C4C4, 32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
        seed_load5(32'd1);
        for (int k = 0; k < 3; k++) drive_share5(sh_a[k*32 +: 32], w);
        seed_ld5 = 1'b1;
        seed5 = 32'd0;
        if5.s_vld = 1'b1;
        if5.s_share = 32'hDEADDEAD;
        #1;
        check("rdy_seed_ld", 384'(if5.s_rdy), 384'd0);
        @(negedge clk);
        seed_ld5 = 1'b0;
        if5.s_vld = 1'b0;
        check("busy_after_seed", 384'(busy5), 384'd0);
        tmp = gen_rnd(32'h2545F491, 0, 5);
        q5.push_back({384'(sh_b), tmp});
        send5(sh_b, 0, fw, tw);
        check("dvld_after_abort", 384'(if5.dvld), 384'd1);
        $display("seed abort sequence done");

        // Second consecutive block continues the PRNG stream.
        tmp = gen_rnd(32'h2545F491, 5, 5);
        q5.push_back({384'(sh_c), tmp});
        send5(sh_c, 0, fw, tw);
        check("rdy_wait_issue", 384'(fw), 384'd1);
        check("rdy_wait_total", 384'(tw), 384'd1);
        check("dvld_second", 384'(if5.dvld), 384'd1);
        @(negedge clk);
        $display("consecutive block sequence done");

        // 8-share instance: async reset during WAIT_RND, then a full block.
        for (int k = 0; k < 8; k++) begin
            sh8a[k*32 +: 32] = $urandom;
            sh8b[k*32 +: 32] = $urandom;
        end
        @(negedge clk);
        rst_n8 = 1'b0;
        #1;
        @(negedge clk);
        rst_n8 = 1'b1;
        if8.s_vld = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if8.s_share = sh8a[k*32 +: 32];
            @(negedge clk);
        end
        if8.s_vld = 1'b0;
        #1;
        check("n8_wait_rdy", 384'(if8.s_rdy), 384'd0);
        check("n8_wait_dvld", 384'(if8.dvld), 384'd0);
        check("n8_wait_busy", 384'(busy8), 384'd1);
        #1;
        rst_n8 = 1'b0;
        #1;
        check("n8_rst_x", 384'(if8.o_x), 384'd0);
        check("n8_rst_rnd", 384'(if8.o_rnd), 384'd0);
        check("n8_rst_dvld", 384'(if8.dvld), 384'd0);
        check("n8_rst_busy", 384'(busy8), 384'd0);
        @(negedge clk);
        rst_n8 = 1'b1;
        tmp = gen_rnd(32'h2545F491, 0, 12);
        q8.push_back({384'(sh8b), tmp});
        if8.s_vld = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if8.s_share = sh8b[k*32 +: 32];
            @(negedge clk);
        end
        if8.s_vld = 1'b0;
        check("n8_dvld_early", 384'(if8.dvld), 384'd0);
        cyc = 0;
        while (!if8.dvld && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("n8_dvld_lat", 384'(cyc), 384'd4);
        @(negedge clk);
        $display("n8 reset sequence done");

        repeat (3) @(negedge clk);
        check("q5_empty", 384'(q5.size()), 384'd0);
        check("q8_empty", 384'(q8.size()), 384'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
